// File: rtl/regfile_debug_master.sv
// Debug-port initiator for the 8 x 8-bit CPU register file.
// Halts the core via halt_req/halt_ack, then reads, writes or dumps the file
// and returns each result on a valid/ready response channel.
module regfile_debug_master #(
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_reg,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       rsp_err,
  output logic       halt_req,
  input  logic       halt_ack,
  output logic [2:0] rf_read_reg,
  input  logic [7:0] rf_read_data,
  output logic       rf_write_en,
  output logic [2:0] rf_write_reg,
  output logic [7:0] rf_write_data
);

  typedef enum logic [1:0] {StIdle, StHalt, StExec, StResp} state_e;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpDump  = 2'b10;
  localparam logic [1:0] OpBad   = 2'b11;

  state_e     state_q, state_d;
  logic [1:0] op_q;
  logic [2:0] reg_q;
  logic [7:0] data_q;
  logic [2:0] idx_q;
  logic [7:0] cnt_q;
  logic       halt_q;
  logic [2:0] rsp_reg_q;
  logic [7:0] rsp_data_q;
  logic       rsp_last_q;
  logic       rsp_err_q;

  logic timeout_hit;
  logic dump_more;

  // Last waiting cycle is the HALT_TIMEOUT-th one spent in HALT.
  assign timeout_hit = (cnt_q == 8'(HALT_TIMEOUT - 1));
  // Another dump beat follows only after a successful, non-final beat.
  assign dump_more   = (op_q == OpDump) && (idx_q != 3'd7) && !rsp_err_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) state_d = (cmd_op == OpBad) ? StResp : StHalt;
      end
      StHalt: begin
        if (halt_ack)         state_d = StExec;
        else if (timeout_hit) state_d = StResp;
      end
      StExec: state_d = StResp;
      StResp: begin
        if (rsp_ready) state_d = dump_more ? StExec : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Command latch, counters, halt request and registered response fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= 2'b00;
      reg_q      <= 3'd0;
      data_q     <= 8'h00;
      idx_q      <= 3'd0;
      cnt_q      <= 8'h00;
      halt_q     <= 1'b0;
      rsp_reg_q  <= 3'd0;
      rsp_data_q <= 8'h00;
      rsp_last_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            reg_q  <= cmd_reg;
            data_q <= cmd_data;
            idx_q  <= 3'd0;
            cnt_q  <= 8'h00;
            if (cmd_op == OpBad) begin
              rsp_reg_q  <= cmd_reg;
              rsp_data_q <= 8'h00;
              rsp_last_q <= 1'b1;
              rsp_err_q  <= 1'b1;
            end else begin
              halt_q <= 1'b1;
            end
          end
        end
        StHalt: begin
          if (!halt_ack) begin
            if (timeout_hit) begin
              halt_q     <= 1'b0;
              rsp_reg_q  <= reg_q;
              rsp_data_q <= 8'h00;
              rsp_last_q <= 1'b1;
              rsp_err_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StExec: begin
          rsp_err_q <= 1'b0;
          if (op_q == OpDump) begin
            rsp_reg_q  <= idx_q;
            rsp_data_q <= rf_read_data;
            rsp_last_q <= (idx_q == 3'd7);
          end else begin
            rsp_reg_q  <= reg_q;
            rsp_last_q <= 1'b1;
            if (op_q == OpRead)    rsp_data_q <= rf_read_data;
            else if (reg_q == 3'd0) rsp_data_q <= 8'h00;
            else                    rsp_data_q <= data_q;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            if (dump_more) idx_q <= idx_q + 3'd1;
            else           halt_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: handshakes from state, register-file ports only during EXEC.
  always_comb begin
    cmd_ready     = (state_q == StIdle);
    rsp_valid     = (state_q == StResp);
    rsp_reg       = rsp_reg_q;
    rsp_data      = rsp_data_q;
    rsp_last      = rsp_last_q;
    rsp_err       = rsp_err_q;
    halt_req      = halt_q;
    rf_read_reg   = 3'd0;
    rf_write_en   = 1'b0;
    rf_write_reg  = 3'd0;
    rf_write_data = 8'h00;
    if (state_q == StExec) begin
      rf_read_reg = (op_q == OpDump) ? idx_q : reg_q;
      if (op_q == OpWrite) begin
        rf_write_en   = (reg_q != 3'd0);
        rf_write_reg  = reg_q;
        rf_write_data = data_q;
      end
    end
  end

endmodule
